// File: rtl/seg_scan_decoder.sv
// Recovers per-digit hex values from a multiplexed seven-segment bus and presents them as whole frames.
// Latency: cap_strobe comes STABLE cycles after a pattern first appears; frame_valid comes 1 cycle after the last capture.
// Backpressure: none. The bus is only observed, and each frame is published as a 1-cycle pulse.
module seg_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an_in,
  input  logic [7:0]            seg_in,
  output logic                  cap_strobe,
  output logic                  frame_valid,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     err
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

  logic [DIGITS+7:0]   cur, prev;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                armed, armed_nxt;
  logic                same, capture, full;
  logic [4:0]          dec;
  logic [4*DIGITS-1:0] sh_dig;
  logic [DIGITS-1:0]   sh_dp, sh_err, seen;

  // Result is {illegal, value}; unknown patterns decode to 0 with the illegal flag set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F: decode = 5'h00;
      7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;
      7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;
      7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;
      7'h07: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;
      7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;
      7'h71: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    cur       = {an_in, seg_in};
    same      = (cur == prev);
    cnt_nxt   = CW'(1);
    armed_nxt = 1'b1;
    if (same) begin
      cnt_nxt   = (cnt == STABLE_C) ? cnt : cnt + CW'(1);
      armed_nxt = armed;
    end
    // Capture is evaluated on the edge that completes the dwell, so the strobe lands in the next cycle.
    capture = armed_nxt && (cnt_nxt == STABLE_C) && $onehot(an_in);
    full    = &seen;
    dec     = decode(seg_in[6:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev        <= '0;
      cnt         <= '0;
      armed       <= 1'b1;
      cap_strobe  <= 1'b0;
      frame_valid <= 1'b0;
      digits      <= '0;
      dp          <= '0;
      err         <= '0;
      sh_dig      <= '0;
      sh_dp       <= '0;
      sh_err      <= '0;
      seen        <= '0;
    end else begin
      prev        <= cur;
      cnt         <= cnt_nxt;
      armed       <= armed_nxt & ~capture;
      cap_strobe  <= capture;
      frame_valid <= full;
      if (full) begin
        digits <= sh_dig;
        dp     <= sh_dp;
        err    <= sh_err;
      end
      // A capture in the publish cycle starts the next frame rather than being lost.
      seen <= (full ? '0 : seen) | (capture ? an_in : '0);
      for (int i = 0; i < DIGITS; i++) begin
        if (capture && an_in[i]) begin
          sh_dig[4*i +: 4] <= dec[3:0];
          sh_dp[i]         <= seg_in[7];
          sh_err[i]        <= dec[4];
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: table-driven scan patterns with capture and frame scoreboards.
module tb_seg_scan_decoder;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an_in;
  logic [7:0]  seg_in;
  logic        cap_strobe, frame_valid;
  logic [15:0] digits;
  logic [3:0]  dp, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  seg;
    int          n;
    bit          cap;
    bit          fr;
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  err;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frm_t;

  vec_t tbl[$];
  int   capq[$];
  frm_t frq[$];

  seg_scan_decoder #(.DIGITS(4), .STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .an_in(an_in), .seg_in(seg_in),
    .cap_strobe(cap_strobe), .frame_valid(frame_valid),
    .digits(digits), .dp(dp), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] an, input logic [7:0] seg, input int n, input bit cap,
                     input bit fr = 0, input logic [15:0] dg = '0,
                     input logic [3:0] d = '0, input logic [3:0] e = '0);
    vec_t v;
    v.an = an; v.seg = seg; v.n = n; v.cap = cap; v.fr = fr; v.dig = dg; v.dp = d; v.err = e;
    tbl.push_back(v);
  endtask

  // Inputs change just after a clock edge; the capture is due STABLE edges later.
  task automatic run(input vec_t v);
    frm_t f;
    an_in  = v.an;
    seg_in = v.seg;
    if (v.cap) capq.push_back(cyc + STABLE);
    if (v.fr) begin
      f.cyc = cyc + STABLE + 1; f.dig = v.dig; f.dp = v.dp; f.err = v.err;
      frq.push_back(f);
    end
    repeat (v.n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (cap_strobe === 1'b1) begin
      if (capq.size() == 0) chk("cap_strobe unexpected", {31'd0, cap_strobe}, 32'd0);
      else chk("cap_strobe cycle", cyc, capq.pop_front());
    end
    if (frame_valid === 1'b1) begin
      if (frq.size() == 0) chk("frame_valid unexpected", {31'd0, frame_valid}, 32'd0);
      else begin
        frm_t f;
        f = frq.pop_front();
        chk("frame cycle", cyc, f.cyc);
        chk("frame digits", {16'd0, digits}, {16'd0, f.dig});
        chk("frame dp", {28'd0, dp}, {28'd0, f.dp});
        chk("frame err", {28'd0, err}, {28'd0, f.err});
      end
    end
  end

  initial begin
    // basic scan 3,2,1,0
    add(4'b0001, 8'h4F, 6, 1);
    add(4'b0010, 8'h5B, 6, 1);
    add(4'b0100, 8'h06, 6, 1);
    add(4'b1000, 8'h3F, 6, 1, 1, 16'h0123, 4'b0000, 4'b0000);
    // short dwell, then dp and illegal pattern; exact-STABLE dwell captures
    add(4'b0001, 8'h06, 3, 0);
    add(4'b0100, 8'hFF, 6, 1);
    add(4'b0010, 8'h66, 4, 1);
    add(4'b1000, 8'h7D, 6, 1);
    add(4'b0001, 8'h2A, 6, 1, 1, 16'h6840, 4'b0100, 4'b0001);
    // multi-hot and idle select, long dwell, overwrite of a seen digit
    add(4'b0011, 8'h3F, 10, 0);
    add(4'b0000, 8'h3F, 10, 0);
    add(4'b0001, 8'h6D, 20, 1);
    add(4'b0001, 8'h66, 6, 1);
    add(4'b0010, 8'h07, 6, 1);
    add(4'b0100, 8'h7F, 6, 1);
    add(4'b1000, 8'h71, 6, 1, 1, 16'hF874, 4'b0000, 4'b0000);

    rst = 1'b1; an_in = '0; seg_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset digits", {16'd0, digits}, 32'd0);
    chk("reset dp", {28'd0, dp}, 32'd0);
    chk("reset err", {28'd0, err}, 32'd0);
    chk("reset cap_strobe", {31'd0, cap_strobe}, 32'd0);
    chk("reset frame_valid", {31'd0, frame_valid}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);
    repeat (3) @(posedge clk);
    #1;
    chk("held digits", {16'd0, digits}, 32'h0000F874);

    // partial frame discarded by a 1-cycle reset
    tbl.delete();
    add(4'b0001, 8'h3F, 6, 1);
    add(4'b0010, 8'h06, 6, 1);
    add(4'b0100, 8'h5B, 6, 1);
    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid-frame reset digits", {16'd0, digits}, 32'd0);
    tbl.delete();
    add(4'b0001, 8'h6F, 6, 1);
    add(4'b0010, 8'h77, 6, 1);
    add(4'b0100, 8'h7C, 6, 1);
    add(4'b1000, 8'h39, 6, 1, 1, 16'hCBA9, 4'b0000, 4'b0000);
    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);
    repeat (5) @(posedge clk);
    #1;
    chk("final digits", {16'd0, digits}, 32'h0000CBA9);
    chk("final frame_valid idle", {31'd0, frame_valid}, 32'd0);
    chk("captures outstanding", capq.size(), 32'd0);
    chk("frames outstanding", frq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
